// File: rtl/ce_pkg.sv
// ce_pkg: shared types for the CE rate controller.
// Rate index, clamp limit, busy/held state encoding.
package ce_pkg;

    typedef logic [1:0] rate_idx_t;

    localparam rate_idx_t RATE_CLAMP = 2'd2;
    localparam int        ACC_W_DEF  = 32;

    // bit0 = request pending, bit1 = wrap held off
    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_PEND      = 2'b01,
        ST_HOLD      = 2'b10,
        ST_PEND_HOLD = 2'b11
    } ce_state_t;

    function automatic rate_idx_t clamp_sel(input rate_idx_t sel);
        return (sel > RATE_CLAMP) ? RATE_CLAMP : sel;
    endfunction

endpackage

// File: rtl/ce_accum.sv
// ce_accum: fractional accumulator producing a registered CE pulse.
// A wrap that is due but held keeps the accumulator frozen.
module ce_accum
    import ce_pkg::*;
#(
    parameter logic [31:0] SYS_CLK = 32'd50_000_000,
    parameter int          ACC_W   = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ACC_W-1:0] inc_i,
    input  logic             hold_i,
    output logic             due_o,
    output logic             wrap_o,
    output logic             clk_en_o
);

    localparam logic [ACC_W-1:0] MOD = ACC_W'(SYS_CLK);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             clk_en_q;

    always_comb begin
        due_o  = (acc_q >= MOD);
        wrap_o = due_o && !hold_i;
        acc_d  = acc_q + inc_i;
        if (wrap_o) begin
            acc_d = acc_q - MOD + inc_i;
        end else if (due_o) begin
            acc_d = acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            clk_en_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            clk_en_q <= wrap_o;
        end
    end

    assign clk_en_o = clk_en_q;

endmodule

// File: rtl/ce_rate_ctrl.sv
// ce_rate_ctrl: CE timebase with boundary-aligned rate switching and halt.
// Define CE_STATS_EN to enable the 16-bit ce_count pulse counter.
module ce_rate_ctrl
    import ce_pkg::*;
#(
    parameter logic [31:0] SYS_CLK = 32'd50_000_000,
    parameter logic [31:0] RATE0   = 32'd894_886,
    parameter logic [31:0] RATE1   = 32'd1_789_773,
    parameter logic [31:0] RATE2   = 32'd3_579_545,
    parameter int          ACC_W   = ACC_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rate_sel,
    input  logic        rate_req,
    output logic        rate_busy,
    output logic        rate_ack,
    output logic [1:0]  cur_rate,
    input  logic        halt,
    output logic        halted,
    output logic        clk_en,
    output logic [15:0] ce_count
);

    ce_state_t        state_q;
    ce_state_t        state_d;
    rate_idx_t        cur_q;
    rate_idx_t        pend_q;
    logic             apply_q;
    logic             ack_q;
    logic [ACC_W-1:0] inc;
    logic             due;
    logic             wrap;
    logic             busy;
    logic             busy_d;
    logic             held_d;

    assign busy = state_q[0];

    always_comb begin
        case (cur_q)
            2'd0:    inc = ACC_W'(RATE0);
            2'd1:    inc = ACC_W'(RATE1);
            default: inc = ACC_W'(RATE2);
        endcase
    end

    ce_accum #(
        .SYS_CLK (SYS_CLK),
        .ACC_W   (ACC_W)
    ) u_accum (
        .clk      (clk),
        .reset    (reset),
        .inc_i    (inc),
        .hold_i   (halt),
        .due_o    (due),
        .wrap_o   (wrap),
        .clk_en_o (clk_en)
    );

    // A request arriving while busy is dropped; first one wins.
    always_comb begin
        busy_d  = busy ? !wrap : rate_req;
        held_d  = due && halt;
        state_d = ce_state_t'({held_d, busy_d});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cur_q   <= '0;
            pend_q  <= '0;
            apply_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            apply_q <= wrap && busy;
            ack_q   <= apply_q;
            if (wrap && busy) begin
                cur_q <= pend_q;
            end
            if (rate_req && !busy) begin
                pend_q <= clamp_sel(rate_sel);
            end
        end
    end

    assign rate_busy = busy;
    assign halted    = state_q[1];
    assign rate_ack  = ack_q;
    assign cur_rate  = cur_q;

`ifdef CE_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (wrap) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign ce_count = cnt_q;
`else
    assign ce_count = '0;
`endif

endmodule
